// File: rtl/din_debouncer_if.sv
`timescale 1ns/1ps
// Signal bundle between a raw pin source and din_debouncer.
// glitch_cnt is only present when DEB_GLITCH_CNT_EN is defined.
interface din_debouncer_if;
  logic       din_raw;
  logic       dout;
  logic       rise;
  logic       fall;
  logic       busy;
`ifdef DEB_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;

  modport master (output din_raw, input dout, rise, fall, busy, glitch_cnt);
  modport slave  (input din_raw, output dout, rise, fall, busy, glitch_cnt);
`else
  modport master (output din_raw, input dout, rise, fall, busy);
  modport slave  (input din_raw, output dout, rise, fall, busy);
`endif
endinterface

// File: rtl/din_debouncer.sv
`timescale 1ns/1ps
// Synchronise and debounce a raw pin into a clean level with rise/fall strobes.
// Define DEB_GLITCH_CNT_EN to add a saturating count of rejected transitions.
module din_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  din_debouncer_if.slave bus
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LO  = 2'd0,
    CHECK_HI = 2'd1,
    IDLE_HI  = 2'd2,
    CHECK_LO = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.din_raw};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt tracks qualifying cycles seen in CHECK_*; it is cleared whenever the FSM settles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = CHECK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = CHECK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = (state_q == CHECK_HI) || (state_q == CHECK_LO);

`ifdef DEB_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic       reject;

  // A rejection is any fall-back from CHECK_* to the idle state it came from.
  assign reject = ((state_q == CHECK_HI) && (state_d == IDLE_LO)) ||
                  ((state_q == CHECK_LO) && (state_d == IDLE_HI));

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (reject && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_cnt_q <= 8'd0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign bus.glitch_cnt = glitch_cnt_q;
`endif

endmodule
